// File: rtl/load_store_unit.sv
// M-stage data-memory access unit: word-aligned req/gnt/rvalid requests, byte lanes, load extension.
// Latency: store 2 stall cycles, load 3; each gnt/rvalid delay cycle extends StallM by one.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q, rdata_q;
  logic [3:0]            mem_be_q;
  logic [1:0]            off_q;
  logic [2:0]            funct3_q;

  logic                  access, is_store, size_byte, size_half, misalign, capture;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d, load_ext;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  ld_signed;

  assign access    = MemReadM | MemWriteM;
  assign is_store  = MemWriteM & ~MemReadM;
  // Funct3 011/110/111 fall through to word size.
  assign size_byte = (Funct3M[1:0] == 2'b00);
  assign size_half = (Funct3M[1:0] == 2'b01);
  assign misalign  = (size_half & ALUResultM[0]) |
                     (~size_byte & ~size_half & (ALUResultM[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    if (is_store) begin
      if (size_byte) begin
        be_d    = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end else if (size_half) begin
        be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
    end
  end

  always_comb begin
    ld_byte   = mem_rdata[8*off_q +: 8];
    ld_half   = mem_rdata[16*off_q[1] +: 16];
    ld_signed = ~funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misalign) begin
            MisalignM = 1'b1;
          end else begin
            StallM  = 1'b1;
            capture = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        StallM = 1'b1;
        if (mem_gnt) state_d = mem_we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        StallM = 1'b1;
        if (mem_rvalid) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Reset overrides everything, including the combinational handshake outputs.
    if (rst) begin
      state_d   = S_IDLE;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      rdata_q     <= '0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      if (capture) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= is_store;
        mem_addr_q  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_q <= wdata_d;
        mem_be_q    <= be_d;
        off_q       <= ALUResultM[1:0];
        funct3_q    <= Funct3M;
      end else if (state_q == S_REQ && mem_gnt) begin
        mem_req_q <= 1'b0;
      end
      if (state_q == S_WAIT && mem_rvalid) rdata_q <= load_ext;
    end
  end

  assign ReadDataM = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit: scripted memory responder plus load-result scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // One access: drives the M-stage inputs, answers the memory port and checks request,
  // request length, stall length and (for loads) the scoreboarded ReadDataM.
  task automatic do_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic [31:0] exp_rd, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input int exp_stall);
    int stall_n = 0, req_n = 0, wait_n = 0;
    bit done = 0;
    logic [31:0] exp;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    if (rd) exp_q.push_back(exp_rd);
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (StallM) begin
        stall_n++;
        if (mem_req) begin
          req_n++;
          if (req_n == 1) begin
            checks++;
            if (mem_addr !== exp_addr || mem_be !== exp_be || mem_we !== (wr & ~rd) ||
                (!rd && mem_wdata !== exp_wd)) begin
              errors++;
              $display("FAIL %s request: addr=%h be=%b we=%b wdata=%h, expected addr=%h be=%b we=%b wdata=%h",
                       nm, mem_addr, mem_be, mem_we, mem_wdata, exp_addr, exp_be, wr & ~rd, exp_wd);
            end
          end
          mem_gnt = (req_n > gnt_dly);
        end else if (req_n > 0) begin
          wait_n++;
          mem_gnt = 1'b0;
          mem_rvalid = (wait_n > rv_dly);
          mem_rdata = mem_rvalid ? rdata : 32'h0;
        end
      end else begin
        done = 1;
        MemReadM = 1'b0; MemWriteM = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (stall_n != exp_stall || req_n != gnt_dly + 1) begin
          errors++;
          $display("FAIL %s timing: stall=%0d req=%0d, expected stall=%0d req=%0d",
                   nm, stall_n, req_n, exp_stall, gnt_dly + 1);
        end
        if (rd) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          checks++;
          if (ReadDataM !== exp) begin
            errors++;
            $display("FAIL %s ReadDataM: got %h expected %h", nm, ReadDataM, exp);
          end
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: StallM never dropped", nm);
      MemReadM = 1'b0; MemWriteM = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
    ALUResultM = 32'h100; WriteDataM = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if (StallM !== 1'b0 || MisalignM !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: StallM=%b MisalignM=%b expected 0 0", StallM, MisalignM);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        mem_be !== 4'b0 || ReadDataM !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: req=%b we=%b addr=%h wdata=%h be=%b rd=%h expected all zero",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM);
    end
    MemReadM = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    do_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
              32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 3);
    @(negedge clk); #1;
    checks++;
    if (ReadDataM !== 32'hDEADBEEF || StallM !== 1'b0) begin
      errors++;
      $display("FAIL lw_hold: ReadDataM=%h StallM=%b expected deadbeef 0", ReadDataM, StallM);
    end
  endtask

  task automatic test_load_ext();
    do_access("lb",  1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80112233, 32'hFFFFFF80, 32'h100, 4'b1111, 0, 3);
    do_access("lbu", 1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80112233, 32'h00000080, 32'h100, 4'b1111, 0, 3);
    do_access("lb1", 1, 0, 3'b000, 32'h101, 0, 0, 0, 32'h80112233, 32'h00000022, 32'h100, 4'b1111, 0, 3);
    do_access("lh",  1, 0, 3'b001, 32'h102, 0, 0, 0, 32'h80017FFF, 32'hFFFF8001, 32'h100, 4'b1111, 0, 3);
    do_access("lhu", 1, 0, 3'b101, 32'h102, 0, 0, 0, 32'h80017FFF, 32'h00008001, 32'h100, 4'b1111, 0, 3);
    do_access("lh0", 1, 0, 3'b001, 32'h100, 0, 0, 0, 32'h80017FFF, 32'h00007FFF, 32'h100, 4'b1111, 0, 3);
    do_access("lw_slow", 1, 0, 3'b010, 32'h7FC, 0, 1, 2, 32'h13579BDF, 32'h13579BDF, 32'h7FC, 4'b1111, 0, 6);
  endtask

  task automatic test_store();
    do_access("sb",  0, 1, 3'b000, 32'h201, 32'h123456AB, 3, 0, 0, 0, 32'h200, 4'b0010, 32'hABABABAB, 5);
    do_access("sh",  0, 1, 3'b001, 32'h302, 32'h9999BEEF, 0, 0, 0, 0, 32'h300, 4'b1100, 32'hBEEFBEEF, 2);
    do_access("sw",  0, 1, 3'b010, 32'h404, 32'hA5A5_0F0F, 0, 0, 0, 0, 32'h404, 4'b1111, 32'hA5A50F0F, 2);
    // Both flags set: treated as a load.
    do_access("rw",  1, 1, 3'b010, 32'h408, 32'h11111111, 0, 0, 32'h2468ACE0, 32'h2468ACE0, 32'h408, 4'b1111, 0, 3);
  endtask

  task automatic test_misalign();
    logic [31:0] addrs[2];
    logic [2:0]  f3s[2];
    logic        wrs[2];
    logic [31:0] prev;
    addrs = '{32'h102, 32'h301}; f3s = '{3'b010, 3'b001}; wrs = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      prev = ReadDataM;
      @(negedge clk);
      MemReadM = ~wrs[i]; MemWriteM = wrs[i]; Funct3M = f3s[i]; ALUResultM = addrs[i];
      WriteDataM = 32'h55AA55AA;
      #1;
      checks++;
      if (MisalignM !== 1'b1 || StallM !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL misalign%0d: MisalignM=%b StallM=%b req=%b expected 1 0 0",
                 i, MisalignM, StallM, mem_req);
      end
      @(negedge clk); #1;
      checks++;
      if (mem_req !== 1'b0 || ReadDataM !== prev) begin
        errors++;
        $display("FAIL misalign%0d_after: req=%b ReadDataM=%h expected 0 %h", i, mem_req, ReadDataM, prev);
      end
      MemReadM = 1'b0; MemWriteM = 1'b0;
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; MemReadM = 1'b0;
    #1;
    checks++;
    if (StallM !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: StallM=%b req=%b expected 1 0", StallM, mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (ReadDataM !== 32'h0 || StallM !== 1'b0 || mem_req !== 1'b0 || mem_be !== 4'b0) begin
      errors++;
      $display("FAIL rst_wait: ReadDataM=%h StallM=%b req=%b be=%b expected 0 0 0 0",
               ReadDataM, StallM, mem_req, mem_be);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_misalign();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected loads never completed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage data-side access unit for the 5-stage RISC-V pipeline. It produces the load data that the M/W pipeline register carries to the writeback result mux as ReadDataW. It converts M-stage load/store controls into word-aligned requests on a req/gnt/rvalid data-memory port. It generates byte enables, store-data replication, load extraction and sign/zero extension, and holds the pipeline through a stall output while a transaction is outstanding.

Parameters:
DATA_WIDTH, 32, data path width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
MemReadM  input  1  M-stage instruction is a load.
MemWriteM  input  1  M-stage instruction is a store.
Funct3M  input  3  access size and sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
ALUResultM  input  ADDR_WIDTH  effective byte address.
WriteDataM  input  DATA_WIDTH  store data, taken from the low bits.
ReadDataM  output  DATA_WIDTH  extended load data to the M/W register (registered).
StallM  output  1  freeze IF..M stages; combinational.
MisalignM  output  1  misaligned-access flag for the current M instruction; combinational.
mem_req  output  1  request valid.
mem_we  output  1  request is a write.
mem_addr  output  ADDR_WIDTH  word address, with bits [1:0] forced to 0.
mem_wdata  output  DATA_WIDTH  replicated store data.
mem_be  output  4  byte enables.
mem_gnt  input  1  memory accepts the request this cycle.
mem_rvalid  input  1  read data valid, no earlier than the cycle after gnt.
mem_rdata  input  DATA_WIDTH  read word.

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ReadDataM=0, and the latched offset and funct3 are 0. StallM and MisalignM are 0 during reset.
- Access: an access is present when MemReadM|MemWriteM. If both are set, MemWriteM is ignored and the access is a load.
- Misalignment rule: word access with addr[1:0]!=0, or half access with addr[0]!=0.
- Funct3 011/110/111 are treated as word accesses.
- IDLE, aligned access:
  - StallM=1.
  - Latch addr/be/wdata/we/funct3/addr[1:0] into the request registers.
  - Next state REQ.
- IDLE, misaligned access:
  - MisalignM=1 and StallM=0.
  - No request is issued and ReadDataM is unchanged.
- REQ: mem_req=1 and StallM=1, with all request outputs held stable until gnt.
  - On mem_gnt, mem_req drops next cycle.
  - Next state is DONE for a store and WAIT for a load.
- WAIT: StallM=1.
  - On mem_rvalid, ReadDataM <= extracted data and next state DONE.
  - Otherwise wait indefinitely.
- DONE: StallM=0, so the pipeline advances at this edge; next state IDLE. ReadDataM holds until the next load completes.
- Byte enables and store data:
  - SB: be=0001<<addr[1:0], wdata=byte replicated x4.
  - SH: be=0011 when addr[1]=0, else 1100; wdata=half replicated x2.
  - SW: be=1111, wdata=WriteDataM.
  - Loads drive be=1111 and mem_we=0.
- Load extraction:
  - byte = rdata[8*off+7:8*off].
  - half = rdata[16*addr[1]+15:16*addr[1]].
  - Signed loads sign-extend to 32 bits; 100/101 zero-extend.
- Latency with gnt in the first REQ cycle:
  - Store: 2 stall cycles (IDLE, REQ).
  - Load with rvalid the next cycle: 3 stall cycles (IDLE, REQ, WAIT).
  - Each cycle of gnt or rvalid delay adds one stall cycle.
- mem_rvalid in IDLE/REQ/DONE is ignored; mem_gnt outside REQ is ignored.
- Reset in any state aborts the transaction: return to IDLE and clear the outputs. A late rvalid after reset is ignored.

Test Plan:
1. LW at 0x100, gnt in the first REQ cycle, rvalid the next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, StallM high exactly 3 cycles, ReadDataM=0xDEADBEEF from DONE onward.
2. LB at 0x103 with rdata=0x80112233 -> ReadDataM=0xFFFFFF80; LBU at the same address -> 0x00000080.
3. LH at 0x102 with rdata=0x80017FFF -> ReadDataM=0xFFFF8001; LHU -> 0x00008001; LH at 0x100 -> 0x00007FFF.
4. SB at 0x201 with WriteDataM=0x123456AB and gnt withheld 3 cycles -> mem_addr=0x200, be=0010, wdata=0xABABABAB, mem_we=1, mem_req held 4 cycles, StallM high 5 cycles.
5. LW at 0x102 and SH at 0x301 -> MisalignM=1, mem_req never asserts, StallM=0, ReadDataM unchanged.
6. LW issued, rst asserted in WAIT, rvalid with 0xCAFEF00D the following cycle -> state IDLE, ReadDataM=0, StallM=0, no capture.
